// File: rtl/result_receiver.sv
// ---------------------------------------------------------------------------
// result_receiver
//
// Receives 9-byte result frames from the output_loader byte stream. Each frame
// is laid out as follows:
//   {SYNC[4:0], mode[2:0]}, wordA[31:24..7:0], wordB[31:24..7:0]
// Bytes are MSB first. A completed frame is presented on mode/wordA/wordB and
// held with res_valid until the consumer acknowledges it.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   in_byte    in   [7:0] stream byte
//   in_valid   in   in_byte valid; one byte per asserted cycle
//   ack        in   consumer has taken the held result (ignored outside HOLD)
//   mode       out  [2:0]  regime field of the last completed frame
//   wordA      out  [31:0] kappa word of the last completed frame
//   wordB      out  [31:0] inv_kappa word of the last completed frame
//   res_valid  out  result held, level until ack
//   busy       out  frame reception in progress
//   frame_err  out  one-cycle pulse: bad header or inter-byte timeout
//   overrun    out  one-cycle pulse: byte dropped while a result was held
// ---------------------------------------------------------------------------
module result_receiver #(
  parameter logic [4:0] SYNC    = 5'b10101,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        ack,
  output logic [2:0]  mode,
  output logic [31:0] wordA,
  output logic [31:0] wordB,
  output logic        res_valid,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int GW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX_A = 2'd1,
    RX_B = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [2:0]    mode_sh_reg, mode_sh_next;
  logic [31:0]   sha_reg, sha_next;
  logic [31:0]   shb_reg, shb_next;
  logic [2:0]    mode_reg, mode_next;
  logic [31:0]   word_a_reg, word_a_next;
  logic [31:0]   word_b_reg, word_b_next;
  logic          res_valid_reg, res_valid_next;
  logic          busy_reg, busy_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg, overrun_next;
  logic          take_hdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      gap_reg       <= '0;
      mode_sh_reg   <= '0;
      sha_reg       <= '0;
      shb_reg       <= '0;
      mode_reg      <= '0;
      word_a_reg    <= '0;
      word_b_reg    <= '0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      gap_reg       <= gap_next;
      mode_sh_reg   <= mode_sh_next;
      sha_reg       <= sha_next;
      shb_reg       <= shb_next;
      mode_reg      <= mode_next;
      word_a_reg    <= word_a_next;
      word_b_reg    <= word_b_next;
      res_valid_reg <= res_valid_next;
      busy_reg      <= busy_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    gap_next       = gap_reg;
    mode_sh_next   = mode_sh_reg;
    sha_next       = sha_reg;
    shb_next       = shb_reg;
    mode_next      = mode_reg;
    word_a_next    = word_a_reg;
    word_b_next    = word_b_reg;
    res_valid_next = res_valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    take_hdr       = 1'b0;

    case (state_reg)
      IDLE: begin
        take_hdr = in_valid;
      end

      RX_A, RX_B: begin
        if (in_valid) begin
          // Every byte here is data, even if it looks like a header.
          gap_next = '0;
          cnt_next = cnt_reg + 2'd1;
          if (state_reg == RX_A) begin
            sha_next = {sha_reg[23:0], in_byte};
            if (cnt_reg == 2'd3) begin
              state_next = RX_B;
            end
          end else begin
            shb_next = {shb_reg[23:0], in_byte};
            if (cnt_reg == 2'd3) begin
              // Last byte: publish straight from the shadows so the
              // result appears one cycle after the 9th byte.
              state_next     = HOLD;
              mode_next      = mode_sh_reg;
              word_a_next    = sha_reg;
              word_b_next    = {shb_reg[23:0], in_byte};
              res_valid_next = 1'b1;
            end
          end
        end else if (gap_reg == GW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abandon the frame.
          frame_err_next = 1'b1;
          state_next     = IDLE;
          gap_next       = '0;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      HOLD: begin
        if (ack) begin
          res_valid_next = 1'b0;
          state_next     = IDLE;
          // A byte arriving with the ack is treated as an IDLE byte.
          take_hdr       = in_valid;
        end else if (in_valid) begin
          overrun_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (take_hdr) begin
      if (in_byte[7:3] == SYNC) begin
        mode_sh_next = in_byte[2:0];
        cnt_next     = '0;
        gap_next     = '0;
        state_next   = RX_A;
      end else begin
        frame_err_next = 1'b1;
      end
    end

    busy_next = (state_next == RX_A) || (state_next == RX_B);
  end

  assign mode      = mode_reg;
  assign wordA     = word_a_reg;
  assign wordB     = word_b_reg;
  assign res_valid = res_valid_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_result_receiver.sv
// ---------------------------------------------------------------------------
// tb_result_receiver
//
// The driver applies one input set per clock and steps a byte-list
// reference model. It then pushes the expected output vector for the
// following cycle into a queue. A separate monitor pops one entry per
// cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_result_receiver;

  localparam logic [4:0] SYNC    = 5'b10101;
  localparam int         TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        ack;
  logic [2:0]  mode;
  logic [31:0] wordA;
  logic [31:0] wordB;
  logic        res_valid;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  result_receiver #(.SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .ack(ack),
    .mode(mode), .wordA(wordA), .wordB(wordB), .res_valid(res_valid),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        rv;
    logic        busy;
    logic        fe;
    logic        ov;
  } out_t;

  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: the bytes of the frame collected so far.
  logic [7:0] m_bytes[$];
  int         m_idle;
  bit         m_held;
  out_t       m_out;

  task automatic model_header(input logic [7:0] b);
    if (b[7:3] == SYNC) begin
      m_bytes.delete();
      m_bytes.push_back(b);
      m_idle = 0;
    end else begin
      m_out.fe = 1'b1;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit a, input bit r);
    if (r) begin
      m_bytes.delete();
      m_idle = 0;
      m_held = 0;
      m_out  = '0;
    end else begin
      m_out.fe = 1'b0;
      m_out.ov = 1'b0;
      if (m_bytes.size() != 0) begin
        if (v) begin
          m_bytes.push_back(b);
          m_idle = 0;
          if (m_bytes.size() == 9) begin
            m_out.mode = m_bytes[0][2:0];
            m_out.a = {m_bytes[1], m_bytes[2], m_bytes[3], m_bytes[4]};
            m_out.b = {m_bytes[5], m_bytes[6], m_bytes[7], m_bytes[8]};
            m_held = 1;
            m_bytes.delete();
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_out.fe = 1'b1;
            m_bytes.delete();
            m_idle = 0;
          end
        end
      end else if (m_held) begin
        if (a) begin
          m_held = 0;
          if (v) model_header(b);
        end else if (v) begin
          m_out.ov = 1'b1;
        end
      end else if (v) begin
        model_header(b);
      end
      m_out.rv   = m_held;
      m_out.busy = (m_bytes.size() != 0);
    end
  endtask

  // Drives one cycle: inputs are applied 2 time units after a rising edge.
  task automatic step(input bit v, input logic [7:0] b, input bit a, input bit r);
    in_valid = v;
    in_byte  = b;
    ack      = a;
    rst      = r;
    model_step(v, b, a, r);
    exp_q.push_back(m_out);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [2:0] m, input logic [31:0] a,
                            input logic [31:0] b, input int gap_max, input bit rnd_ack);
    logic [7:0] fb[9];
    fb[0] = {SYNC, m};
    for (int i = 0; i < 4; i++) begin
      fb[1+i] = a[31-8*i -: 8];
      fb[5+i] = b[31-8*i -: 8];
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, fb[i], rnd_ack && ($urandom_range(0, 3) == 0), 1'b0);
      if (i < 8 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  // Monitor: one comparison per cycle, 1 time unit after the rising edge.
  initial begin
    out_t act;
    out_t exp;
    logic prev_rv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = '{mode, wordA, wordB, res_valid, busy, frame_err, overrun};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t: got mode=%0d A=%h B=%h rv=%b busy=%b fe=%b ov=%b, expected mode=%0d A=%h B=%h rv=%b busy=%b fe=%b ov=%b",
                   $time, act.mode, act.a, act.b, act.rv, act.busy, act.fe, act.ov,
                   exp.mode, exp.a, exp.b, exp.rv, exp.busy, exp.fe, exp.ov);
        end
        if (act.rv && !prev_rv)
          $display("frame t=%0t mode=%0d wordA=%h wordB=%h", $time, act.mode, act.a, act.b);
        prev_rv = act.rv;
      end
    end
  end

  initial begin
    m_bytes.delete();
    m_idle = 0;
    m_held = 0;
    m_out  = '0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    ack      = 1'b0;
    rst      = 1'b1;

    // Reset state.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Back-to-back reference frame.
    send_frame(3'd1, 32'h12345678, 32'hFFFFFFFE, 0, 1'b0);
    idle(2);
    // Byte dropped while held, then ack together with a new header.
    step(1'b1, 8'hA8, 1'b0, 1'b0);
    step(1'b1, 8'hA8, 1'b1, 1'b0);
    // Header byte inside the frame is treated as data.
    send_frame(3'd5, 32'hA8A9AAAB, 32'h80000000, 0, 1'b0);
    idle(1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // A bad header is rejected; ack outside HOLD is ignored.
    step(1'b1, 8'h35, 1'b1, 1'b0);
    idle(2);
    // Timeout after two data bytes.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    idle(TIMEOUT + 2);
    // A gap of TIMEOUT-1 cycles is still accepted.
    step(1'b1, 8'hAF, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // Reset after the 5th byte, then a clean frame with 3-cycle gaps.
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0) ? 8'hAB : 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i == 0) ? 8'hAE : 8'(8'hC0 + i), 1'b0, 1'b0);
      if (i < 8) idle(3);
    end
    idle(2);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0: step(1'b1, 8'($urandom), 1'b0, 1'b0);
        1: step(1'b0, 8'h00, 1'b1, 1'b0);
        2: idle($urandom_range(1, 4));
        3: step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 3) == 0));
        4: begin
          step(1'b1, {SYNC, 3'($urandom)}, 1'b0, 1'b0);
          idle($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
        end
        default: send_frame(3'($urandom), $urandom, $urandom,
                            ($urandom_range(0, 2) == 0) ? 4 : 0, 1'b1);
      endcase
    end
    idle(3);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
